fp_align_shift: RTL
===================

# fp_align_shift

Mantissa alignment stage for the FP16 add/subtract datapath. Sits directly downstream of the 8-bit exponent subtractor. It takes the exponent difference magnitude and its sign flag, swaps the operands so the larger-exponent one is first, and right-shifts the smaller mantissa one bit per clock with guard/round/sticky tracking. Aligned mantissas and the result exponent go to the mantissa adder under a valid/ready handshake.

## Interface
Parameters:
- MANT_W, 11, mantissa width including hidden bit
- EXP_W, 5, exponent width
- DIFF_W, 8, exponent-difference width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset; asynchronous, active-high
- in_valid  input  1  operand set present
- in_ready  output  1  block can accept (IDLE only)
- exp_diff  input  DIFF_W  |exp_a − exp_b|
- a_ge_b  input  1  1 when exp_a ≥ exp_b (subtractor no-borrow)
- exp_a, exp_b  input  EXP_W  operand exponents
- man_a, man_b  input  MANT_W  operand mantissas
- out_valid  output  1  aligned result present
- out_ready  input  1  consumer accepts
- exp_out  output  EXP_W  larger exponent
- man_big  output  MANT_W+3  {larger-exp mantissa, 3'b000}
- man_small  output  MANT_W+3  {shifted mantissa, G, R, S}
- swapped  output  1  1 when operand B was larger

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. On in_valid, latch inputs. If a_ge_b=1, big=A and small=B; otherwise swap and set swapped=1. Load small as {man, 3'b000} and cnt=exp_diff.
  - exp_diff ≥ MANT_W+3 (saturation): small becomes 0, with S = OR of the mantissa; next state is DONE.
  - exp_diff = 0: next state is DONE.
  - otherwise: next state is SHIFT.
- SHIFT: each cycle, small = {0, small[top:2], small[1]|small[0]}, so sticky ORs everything shifted past R. cnt decrements each cycle. When cnt reaches 1, that final shift is applied and the next state is DONE.
- DONE: out_valid=1 and outputs are held stable. On out_ready, return to IDLE. There is no same-cycle re-accept; in_ready rises the cycle after the handshake.
- exp_diff is treated as unsigned. The a_ge_b=1, exp_diff=0 tie selects A.
- Reset at any time: state goes to IDLE and any in-flight transaction is discarded.
- Reset values: out_valid=0, in_ready=1, swapped=0, exp_out=0, man_big=0, man_small=0.

## Timing
- Acceptance in cycle t gives out_valid in cycle t+1+N.
  - N = exp_diff when 0 < exp_diff < MANT_W+3.
  - N = 0 otherwise.
- Maximum latency is MANT_W+3 = 14 cycles.
- Throughput is one operation per (latency + 1 + out_ready wait) cycles.
- All outputs are registered; there is no combinational input→output path.
- in_ready depends only on state.

## Configuration
- FP_ALIGN_GRS_EN defined: G/R/S tracking as described above.
- FP_ALIGN_GRS_EN undefined:
  - bits shifted past the mantissa LSB are discarded.
  - man_small[2:0] is always 0.
  - a saturated small operand is exactly 0.
- Port widths are identical in both builds.

## Structure
- Shared package fp16_pkg holds:
  - EXP_W, MANT_W, GRS_W=3
  - SAT_SHIFT = MANT_W+GRS_W
  - align_state_t enum {IDLE, SHIFT, DONE}
- One natural sub-module: sticky_rshift1, a combinational one-bit right shift with sticky OR. Its OR term is gated by FP_ALIGN_GRS_EN.

## Test plan
- Basic shift: exp_a=15, exp_b=13, exp_diff=2, a_ge_b=1, man_a=11'h400, man_b=11'h600. Expect out_valid at t+3; exp_out=15; man_big=14'h2000; man_small=14'h0C00; swapped=0.
- Sticky capture: exp_diff=4, a_ge_b=1, man_b=11'h401. Expect man_small=14'h0201 with macro defined, 14'h0200 without; latency 5.
- Swap: exp_a=10, exp_b=14, exp_diff=4, a_ge_b=0. Expect exp_out=14; man_big={man_b,000}; swapped=1.
- Saturation: exp_diff=20, man_small input 11'h7FF. Expect out_valid at t+1; man_small=14'h0001 with macro defined, 0 without. Repeat with exp_diff=0: expect out_valid at t+1 and man_small={man,000}.
- Backpressure: hold out_ready=0 for 5 cycles in DONE. Outputs must stay stable with in_ready=0. After the out_ready handshake, expect in_ready=1 exactly one cycle later.
- Reset mid-shift: assert rst during SHIFT with exp_diff=10. Expect out_valid=0 and in_ready=1 immediately (asynchronous). A following operation completes with correct latency.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared constants and types for the FP16 add/subtract datapath.
package fp16_pkg;

  localparam int EXP_W     = 5;
  localparam int MANT_W    = 11;
  localparam int GRS_W     = 3;
  localparam int SAT_SHIFT = MANT_W + GRS_W;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } align_state_t;

endpackage

// File: rtl/sticky_rshift1.sv
// One-bit logical right shift that folds the two lowest bits into a sticky LSB.
// The sticky OR is only active when FP_ALIGN_GRS_EN is defined.
module sticky_rshift1 #(
  parameter int W = 14
) (
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data
);

`ifdef FP_ALIGN_GRS_EN
  localparam bit GRS_EN = 1'b1;
`else
  localparam bit GRS_EN = 1'b0;
`endif

  logic w_sticky;

  assign w_sticky = GRS_EN & (i_data[1] | i_data[0]);
  assign o_data   = {1'b0, i_data[W-1:2], w_sticky};

endmodule

// File: rtl/fp_align_shift.sv
// FP16 mantissa alignment: swap by exponent, then shift the smaller mantissa
// one bit per clock. Guard/round/sticky tracking is enabled by FP_ALIGN_GRS_EN.
module fp_align_shift #(
  parameter int MANT_W = fp16_pkg::MANT_W,
  parameter int EXP_W  = fp16_pkg::EXP_W,
  parameter int DIFF_W = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [DIFF_W-1:0]                exp_diff,
  input  logic                             a_ge_b,
  input  logic [EXP_W-1:0]                 exp_a,
  input  logic [EXP_W-1:0]                 exp_b,
  input  logic [MANT_W-1:0]                man_a,
  input  logic [MANT_W-1:0]                man_b,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [EXP_W-1:0]                 exp_out,
  output logic [MANT_W+fp16_pkg::GRS_W-1:0] man_big,
  output logic [MANT_W+fp16_pkg::GRS_W-1:0] man_small,
  output logic                             swapped
);

  import fp16_pkg::*;

`ifdef FP_ALIGN_GRS_EN
  localparam bit GRS_EN = 1'b1;
`else
  localparam bit GRS_EN = 1'b0;
`endif

  localparam int W = MANT_W + GRS_W;
  localparam logic [W-1:0] SMALL_MASK =
    GRS_EN ? {W{1'b1}} : {{(W-GRS_W){1'b1}}, {GRS_W{1'b0}}};

  align_state_t      r_state;
  align_state_t      w_next;
  logic [DIFF_W-1:0] r_cnt;
  logic [EXP_W-1:0]  r_exp;
  logic [W-1:0]      r_big;
  logic [W-1:0]      r_small;
  logic              r_swapped;

  logic [MANT_W-1:0] w_big_man;
  logic [MANT_W-1:0] w_small_man;
  logic [W-1:0]      w_shifted;
  logic [W-1:0]      w_sat_small;
  logic              w_sat;
  logic              w_zero;

  assign w_big_man   = a_ge_b ? man_a : man_b;
  assign w_small_man = a_ge_b ? man_b : man_a;
  assign w_sat       = exp_diff >= DIFF_W'(W);
  assign w_zero      = exp_diff == '0;
  // A fully shifted-out operand leaves only its sticky bit behind.
  assign w_sat_small = {{(W-1){1'b0}}, GRS_EN & (|w_small_man)};

  sticky_rshift1 #(.W(W)) u_shift (
    .i_data (r_small),
    .o_data (w_shifted)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // NOTE: default assignment first so no path through the case leaves w_next
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next = (w_sat || w_zero) ? DONE : SHIFT;
      SHIFT:   if (r_cnt <= DIFF_W'(1)) w_next = DONE;
      DONE:    if (out_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      r_exp     <= '0;
      r_big     <= '0;
      r_small   <= '0;
      r_swapped <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_swapped <= ~a_ge_b;
            r_exp     <= a_ge_b ? exp_a : exp_b;
            r_big     <= {w_big_man, {GRS_W{1'b0}}};
            r_cnt     <= exp_diff;
            r_small   <= w_sat ? w_sat_small : {w_small_man, {GRS_W{1'b0}}};
          end
        end
        SHIFT: begin
          r_small <= w_shifted;
          r_cnt   <= r_cnt - DIFF_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign exp_out   = r_exp;
  assign man_big   = r_big;
  assign man_small = r_small & SMALL_MASK;
  assign swapped   = r_swapped;

endmodule
